// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges per-cycle results onto register-file write ports.
// Optional pending_mask output enabled by defining WB_ARBITER_PENDING_EN.
module wb_arbiter #(
    parameter int NSRC  = 4,
    parameter int NPORT = 2,
    parameter int DEPTH = 8,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     interlock,
    input  logic [NSRC-1:0]          src_valid,
    input  logic [NSRC*AW-1:0]       src_rt,
    input  logic [NSRC*DW-1:0]       src_data,
    output logic [NPORT-1:0]         wr_en,
    output logic [NPORT*AW-1:0]      wr_addr,
    output logic [NPORT*DW-1:0]      wr_data,
    output logic                     stall_req,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     overflow
`ifdef WB_ARBITER_PENDING_EN
    ,
    output logic [2**AW-1:0]         pending_mask
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] q_addr [DEPTH];
    logic [DW-1:0] q_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    int            n_pop;
    int            n_push;
    logic          drop;
    logic [NPORT-1:0] iss_en;
    logic [NPORT-1:0] wen_next;
    logic [AW-1:0] iss_addr [NPORT];
    logic [DW-1:0] iss_data [NPORT];
    logic [NSRC-1:0] push_en;
    logic [PW-1:0] push_idx [NSRC];

    // Queue entries take ports first; sources fill what is left, rest queue up.
    always_comb begin : issue
        int cnt;
        int avail;
        int free;
        int rank;
        int port;
        int j;
        logic [PW-1:0] idx;
        cnt    = int'(q_count);
        n_pop  = (cnt < NPORT) ? cnt : NPORT;
        avail  = NPORT - n_pop;
        free   = DEPTH - cnt + n_pop;
        rank   = 0;
        port   = 0;
        j      = 0;
        idx    = '0;
        n_push = 0;
        drop   = 1'b0;
        iss_en = '0;
        push_en = '0;
        for (int p = 0; p < NPORT; p++) begin
            iss_addr[p] = '0;
            iss_data[p] = '0;
        end
        for (int i = 0; i < NSRC; i++) begin
            push_idx[i] = '0;
        end
        for (int p = 0; p < NPORT; p++) begin
            if (p < n_pop) begin
                idx         = rd_ptr + PW'(p);
                iss_en[p]   = 1'b1;
                iss_addr[p] = q_addr[idx];
                iss_data[p] = q_data[idx];
            end
        end
        for (int i = 0; i < NSRC; i++) begin
            if (src_valid[i]) begin
                if (rank < avail) begin
                    port           = n_pop + rank;
                    iss_en[port]   = 1'b1;
                    iss_addr[port] = src_rt[i*AW +: AW];
                    iss_data[port] = src_data[i*DW +: DW];
                end else begin
                    j = rank - avail;
                    if (j < free) begin
                        push_en[i]  = 1'b1;
                        push_idx[i] = wr_ptr + PW'(j);
                        n_push      = n_push + 1;
                    end else begin
                        drop = 1'b1;
                    end
                end
                rank = rank + 1;
            end
        end
    end

    // A later write to the same register supersedes the earlier one.
    always_comb begin
        wen_next = iss_en;
        for (int p = 0; p < NPORT; p++) begin
            for (int q = p + 1; q < NPORT; q++) begin
                if (iss_en[q] && (iss_addr[q] == iss_addr[p]))
                    wen_next[p] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_en    <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            q_count  <= '0;
            overflow <= 1'b0;
        end else if (interlock) begin
            wr_en <= '0;
        end else begin
            wr_en <= wen_next;
            for (int p = 0; p < NPORT; p++) begin
                wr_addr[p*AW +: AW] <= iss_addr[p];
                wr_data[p*DW +: DW] <= iss_data[p];
            end
            rd_ptr   <= rd_ptr + PW'(n_pop);
            wr_ptr   <= wr_ptr + PW'(n_push);
            q_count  <= q_count - CW'(n_pop) + CW'(n_push);
            overflow <= overflow | drop;
        end
    end

    always_ff @(posedge clk) begin
        if (!interlock) begin
            for (int i = 0; i < NSRC; i++) begin
                if (push_en[i]) begin
                    q_addr[push_idx[i]] <= src_rt[i*AW +: AW];
                    q_data[push_idx[i]] <= src_data[i*DW +: DW];
                end
            end
        end
    end

    assign stall_req = (CW'(DEPTH) - q_count) < CW'(NSRC);

`ifdef WB_ARBITER_PENDING_EN
    logic [2**AW-1:0] pend_next;

    // Mirror of the next-cycle queue contents, one bit per register.
    always_comb begin : pend
        logic [PW-1:0] rd_n;
        logic [PW-1:0] off;
        logic [AW-1:0] a;
        int cnt_n;
        pend_next = '0;
        rd_n  = rd_ptr + PW'(n_pop);
        cnt_n = int'(q_count) - n_pop + n_push;
        off   = '0;
        a     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            a = q_addr[k];
            for (int i = 0; i < NSRC; i++) begin
                if (push_en[i] && (push_idx[i] == PW'(k)))
                    a = src_rt[i*AW +: AW];
            end
            off = PW'(k) - rd_n;
            if (int'(off) < cnt_n)
                pend_next[a] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            pending_mask <= '0;
        else if (!interlock)
            pending_mask <= pend_next;
    end
`endif

endmodule
